// File: rtl/id_ex_stage_pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the ID->EX pipeline stage register:
//   - default widths of control, register-specifier and data fields
//   - bit positions of the individual control signals inside the ctrl word
//   - occupancy encoding of the two-entry (main + skid) stage
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int CTRL_W = 9;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Control word bit positions
    localparam int CTRL_REGDST   = 0;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_ALUOP_LO = 7;
    localparam int CTRL_ALUOP_HI = 8;

    // Occupancy of the stage, encoded as {skid_v, main_v}.
    // {1,0} cannot occur: the skid entry is only ever filled behind main.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_FULL  = 2'b11
    } occ_e;

    function automatic occ_e occ_of(input logic main_v, input logic skid_v);
        return occ_e'({skid_v, main_v});
    endfunction

endpackage

// File: rtl/id_ex_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pipe_if
// Valid/ready beat bus carrying one decoded instruction.
//   valid  : producer offers a beat
//   ready  : consumer accepts the beat this cycle
//   ctrl   : control bits (see pipe_pkg CTRL_* positions)
//   regs   : N_REG register specifiers, word k at [k*REG_W +: REG_W]
//   data   : N_DATA data words, word k at [k*DATA_W +: DATA_W]
// master = producer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface id_ex_stage_pipe_if #(
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int N_DATA = 4,
    parameter int REG_W  = pipe_pkg::REG_W,
    parameter int N_REG  = 2
);
    logic                     valid;
    logic                     ready;
    logic [CTRL_W-1:0]        ctrl;
    logic [N_REG*REG_W-1:0]   regs;
    logic [N_DATA*DATA_W-1:0] data;

    modport master (output valid, output ctrl, output regs, output data, input  ready);
    modport slave  (input  valid, input  ctrl, input  regs, input  data, output ready);
endinterface

// File: rtl/id_ex_stage_pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
// One storage entry of the ID->EX stage: valid bit plus ctrl/regs/data.
//   clk, rst_n : clock, asynchronous active-low reset (clears everything)
//   i_flush    : clear valid and ctrl; regs/data keep their old contents
//   i_load     : capture i_ctrl/i_regs/i_data and set valid
//   i_clear    : clear valid only
//   o_valid, o_ctrl, o_regs, o_data : stored entry
// Priority: flush > load > clear.
// ---------------------------------------------------------------------------
module pipe_slot #(
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int N_DATA = 4,
    parameter int REG_W  = pipe_pkg::REG_W,
    parameter int N_REG  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_load,
    input  logic                     i_clear,
    input  logic [CTRL_W-1:0]        i_ctrl,
    input  logic [N_REG*REG_W-1:0]   i_regs,
    input  logic [N_DATA*DATA_W-1:0] i_data,
    output logic                     o_valid,
    output logic [CTRL_W-1:0]        o_ctrl,
    output logic [N_REG*REG_W-1:0]   o_regs,
    output logic [N_DATA*DATA_W-1:0] o_data
);
    logic                   r_valid;
    logic [CTRL_W-1:0]      r_ctrl;
    logic [N_REG*REG_W-1:0] r_regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_regs  <= '0;
        end else if (i_flush) begin
            // ctrl is zeroed as well, so a squashed entry can never carry
            // live write/branch enables even if valid were misread.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_regs  <= i_regs;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    // Data words are pure transport; each word gets its own register.
    genvar gi;
    generate
        for (gi = 0; gi < N_DATA; gi++) begin : g_word
            logic [DATA_W-1:0] r_word;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_word <= '0;
                end else if (!i_flush && i_load) begin
                    r_word <= i_data[gi*DATA_W +: DATA_W];
                end
            end
            assign o_data[gi*DATA_W +: DATA_W] = r_word;
        end
    endgenerate

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_regs  = r_regs;
endmodule

// File: rtl/id_ex_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pipe
// ID->EX pipeline register with valid/ready handshake, stall back-pressure,
// flush-to-bubble and an optional one-entry skid buffer.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, empties the stage
//   flush   : synchronous squash of held beats and of the beat offered now
//   in_bus  : slave side, beats from ID (valid/ready/ctrl/regs/data)
//   out_bus : master side, beats to EX; ctrl forced to 0 when not valid
// SKID=1: two registered entries, in_ready = ~skid_v (no path from
//         out_ready to in_ready).
// SKID=0: one entry, in_ready = ~main_v | out_ready.
// ---------------------------------------------------------------------------
module id_ex_stage_pipe #(
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int N_DATA = 4,
    parameter int REG_W  = pipe_pkg::REG_W,
    parameter int N_REG  = 2,
    parameter int SKID   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    id_ex_stage_pipe_if.slave    in_bus,
    id_ex_stage_pipe_if.master   out_bus
);
    import pipe_pkg::*;

    logic                     w_in_fire;
    logic                     w_out_fire;
    occ_e                     w_occ;

    logic                     w_main_v;
    logic [CTRL_W-1:0]        w_main_ctrl;
    logic [N_REG*REG_W-1:0]   w_main_regs;
    logic [N_DATA*DATA_W-1:0] w_main_data;

    logic                     w_skid_v;
    logic [CTRL_W-1:0]        w_skid_ctrl;
    logic [N_REG*REG_W-1:0]   w_skid_regs;
    logic [N_DATA*DATA_W-1:0] w_skid_data;

    logic                     w_main_load;
    logic                     w_main_from_skid;
    logic                     w_main_clear;
    logic                     w_skid_load;
    logic                     w_skid_clear;

    // A beat offered during flush is dropped even when in_ready is high.
    assign w_in_fire  = in_bus.valid & in_bus.ready & ~flush;
    assign w_out_fire = w_main_v & out_bus.ready;
    assign w_occ      = occ_of(w_main_v, w_skid_v);

    // Occupancy transitions. With SKID=0 the FULL state is unreachable and
    // ONE + in_fire always implies out_fire, so the skid controls stay idle.
    always_comb begin
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clear     = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        unique case (w_occ)
            OCC_EMPTY: begin
                w_main_load = w_in_fire;
            end
            OCC_ONE: begin
                if (w_out_fire) begin
                    if (w_in_fire) begin
                        w_main_load = 1'b1;
                    end else begin
                        w_main_clear = 1'b1;
                    end
                end else if (w_in_fire) begin
                    w_skid_load = 1'b1;
                end
            end
            OCC_FULL: begin
                if (w_out_fire) begin
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_skid_clear     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .N_DATA (N_DATA),
        .REG_W  (REG_W),
        .N_REG  (N_REG)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctrl  (w_main_from_skid ? w_skid_ctrl : in_bus.ctrl),
        .i_regs  (w_main_from_skid ? w_skid_regs : in_bus.regs),
        .i_data  (w_main_from_skid ? w_skid_data : in_bus.data),
        .o_valid (w_main_v),
        .o_ctrl  (w_main_ctrl),
        .o_regs  (w_main_regs),
        .o_data  (w_main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W),
                .N_DATA (N_DATA),
                .REG_W  (REG_W),
                .N_REG  (N_REG)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_flush (flush),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_ctrl  (in_bus.ctrl),
                .i_regs  (in_bus.regs),
                .i_data  (in_bus.data),
                .o_valid (w_skid_v),
                .o_ctrl  (w_skid_ctrl),
                .o_regs  (w_skid_regs),
                .o_data  (w_skid_data)
            );
            assign in_bus.ready = ~w_skid_v;
        end else begin : g_no_skid
            assign w_skid_v     = 1'b0;
            assign w_skid_ctrl  = '0;
            assign w_skid_regs  = '0;
            assign w_skid_data  = '0;
            assign in_bus.ready = ~w_main_v | out_bus.ready;
        end
    endgenerate

    // Bubbles never present live control bits to EX.
    assign out_bus.valid = w_main_v;
    assign out_bus.ctrl  = w_main_v ? w_main_ctrl : '0;
    assign out_bus.regs  = w_main_regs;
    assign out_bus.data  = w_main_data;
endmodule
